prbs_checker: RTL
=================

// Module: prbs_checker
// PURPOSE
//   Receive-side partner of the 9-bit pseudo-random generator: consumes the 9-bit words it emits,
//   locks onto the LFSR sequence and counts words that deviate from it. Sits downstream of the
//   generator (or any PRBS9 source) and gives the lab a self-checking monitor for the RNG stream.
//   Sequence: next = {cur[7:0], cur[8]^cur[4]} (x^9+x^5+1); all-zero word is illegal.
// PARAMETERS
//   WIDTH        9    word width; shift/tap rule above is fixed for 9
//   LOCK_THRESH  4    consecutive correct predictions needed to go SEARCH->LOCKED (1..15)
//   LOSS_THRESH  3    consecutive mispredictions in LOCKED that drop back to SEARCH (1..15)
//   CNT_W        16   width of err_count (and word_count)
// PORTS
//   clk         input   1      system clock, rising edge
//   rst         input   1      asynchronous, active-low reset
//   in_valid    input   1      in_data carries a word this cycle
//   in_data     input   WIDTH  received word
//   locked      output  1      checker is in LOCKED
//   err_pulse   output  1      one-cycle pulse: previous accepted word mismatched while LOCKED
//   err_count   output  CNT_W  mismatches counted while LOCKED, saturating
//   word_count  output  CNT_W  words accepted while LOCKED, saturating (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, expect=0, run counters=0, all outputs 0.
//   - Words accepted only when in_valid=1; in_valid=0 cycles change nothing (err_pulse->0).
//   - All outputs registered: effect of word accepted on edge N is visible after edge N.
//   - FSM: IDLE -> SEARCH -> LOCKED -> SEARCH.
//     IDLE:   nonzero word: expect<=next(word), match_run<=0, ->SEARCH. Zero word ignored.
//     SEARCH: word==expect: match_run+1, expect<=next(word); when match_run reaches LOCK_THRESH
//             -> LOCKED, miss_run<=0. Mismatch: reseed expect<=next(word), match_run<=0;
//             zero word -> IDLE. No errors counted in IDLE/SEARCH.
//     LOCKED: word==expect: miss_run<=0. Mismatch: err_pulse<=1, err_count+1, miss_run+1;
//             miss_run reaching LOSS_THRESH -> SEARCH, expect<=next(word), match_run<=0, locked<=0.
//             expect<=next(expect) on every accepted word (no reseed from bad data) so a single
//             corrupted word costs exactly one error.
//   - err_count/word_count saturate at all-ones; never wrap; cleared only by reset.
//   - Mismatch that triggers loss of lock still counts and pulses err_pulse that cycle.
//   - Reset mid-stream: immediate return to IDLE; lock must be reacquired from scratch.
// CONFIGURATION
//   PRBS_CHK_STATS_EN defined: word_count increments on every word accepted in LOCKED.
//   Not defined: word_count tied to 0, counter logic absent; all other behaviour identical.
// STRUCTURE
//   prbs_pkg: WIDTH-9 constants, tap positions (8,4), FSM state encoding
//     (IDLE=2'd0, SEARCH=2'd1, LOCKED=2'd2), saturating-increment function.
//   Sub-module prbs9_next: combinational next-word function, instanced for the predictor;
//   FSM, run counters and stats counters stay in prbs_checker.
// TESTING
//   1 Reset then words 001,002,004,008,010,021 one per cycle -> locked=1 after the word 010
//     (4th match), err_count=0, err_pulse never high.
//   2 Locked, send 043 (correct) then 1FF in place of 086, then 10C,... correct -> one err_pulse,
//     err_count=1, locked stays 1 (predictor not reseeded by 1FF).
//   3 Locked, three consecutive wrong words -> err_count +3, locked=0 after 3rd, then 4 correct
//     successors of the 3rd word -> locked=1 again.
//   4 Zero word from IDLE and in SEARCH -> stays/returns IDLE, locked=0, err_count unchanged;
//     in_valid=0 gaps mid-sequence -> no effect on lock or counters.
//   5 Force err_count near saturation (CNT_W=4 build, 20 errors) -> holds at 4'hF, no wrap.
//   6 rst pulsed low mid-LOCKED, asynchronous to clk -> all outputs 0 immediately; with
//     PRBS_CHK_STATS_EN word_count tracks locked words, without it word_count stays 0.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS9 (x^9+x^5+1) checker: word width, tap positions,
// FSM state encoding and a saturating-increment helper.
package prbs_pkg;

  localparam int PRBS_WIDTH = 9;
  localparam int TAP_HI     = 8;
  localparam int TAP_LO     = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Holds at max_val instead of wrapping; callers cast back to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/prbs9_next.sv
// Combinational PRBS9 step: shift left, feed back bit8 ^ bit4 into bit0.
module prbs9_next
  import prbs_pkg::*;
(
  input  logic [PRBS_WIDTH-1:0] cur,
  output logic [PRBS_WIDTH-1:0] nxt
);

  assign nxt = {cur[PRBS_WIDTH-2:0], cur[TAP_HI] ^ cur[TAP_LO]};

endmodule

// File: rtl/prbs_checker.sv
// PRBS9 stream checker: locks onto the LFSR sequence and counts mispredicted words.
// Optional PRBS_CHK_STATS_EN enables the word_count statistics counter.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH       = PRBS_WIDTH,
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [WIDTH-1:0] expect_word;
  logic [3:0]       match_run;
  logic [3:0]       miss_run;

  logic             hit;
  logic             loss;
  logic [3:0]       match_inc;
  logic [3:0]       miss_inc;
  logic [WIDTH-1:0] pred_src;
  logic [WIDTH-1:0] next_word;

  assign hit       = (in_data == expect_word);
  assign match_inc = match_run + 4'd1;
  assign miss_inc  = miss_run + 4'd1;
  assign loss      = (state == ST_LOCKED) && !hit && (miss_inc == 4'(LOSS_THRESH));

  // While locked the predictor free-runs so one bad word costs exactly one error.
  assign pred_src = ((state == ST_LOCKED) && !loss) ? expect_word : in_data;

  prbs9_next u_next (
    .cur (pred_src),
    .nxt (next_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      expect_word <= '0;
      match_run   <= '0;
      miss_run    <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_IDLE: begin
            if (in_data != '0) begin
              expect_word <= next_word;
              match_run   <= '0;
              state       <= ST_SEARCH;
            end
          end
          ST_SEARCH: begin
            if (in_data == '0) begin
              match_run <= '0;
              state     <= ST_IDLE;
            end else if (hit) begin
              expect_word <= next_word;
              if (match_inc == 4'(LOCK_THRESH)) begin
                match_run <= '0;
                miss_run  <= '0;
                locked    <= 1'b1;
                state     <= ST_LOCKED;
              end else begin
                match_run <= match_inc;
              end
            end else begin
              expect_word <= next_word;
              match_run   <= '0;
            end
          end
          ST_LOCKED: begin
            expect_word <= next_word;
            if (hit) begin
              miss_run <= '0;
            end else begin
              err_pulse <= 1'b1;
              err_count <= CNT_W'(sat_inc(32'(err_count), 32'(CNT_MAX)));
              if (loss) begin
                miss_run  <= '0;
                match_run <= '0;
                locked    <= 1'b0;
                state     <= ST_SEARCH;
              end else begin
                miss_run <= miss_inc;
              end
            end
          end
          default: begin
            locked <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef PRBS_CHK_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
    end else if (in_valid && (state == ST_LOCKED)) begin
      word_count <= CNT_W'(sat_inc(32'(word_count), 32'(CNT_MAX)));
    end
  end
`else
  assign word_count = '0;
`endif

endmodule
